mem_stage: RTL

//   MEM pipeline stage: sits between the ex_mem register and the mem_wb register.

---
 rtl/mem_stage.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: byte-serial loads/stores over a shared 8-bit RAM port,
// arbitrated against fetch, with stallreq held until the access completes.
module mem_stage #(
    parameter int unsigned RAM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [3:0]  ex_mem_op,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_sdata,
    input  logic        mem_gnt,
    input  logic [7:0]  ram_din,
    output logic [31:0] mem_wdata,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic        stallreq,
    output logic        mem_req,
    output logic [31:0] ram_addr,
    output logic [7:0]  ram_dout,
    output logic        ram_we
);

    // Counter covers up to 4 issue cycles plus the read latency tail.
    localparam int unsigned CW = $clog2(RAM_LAT + 5);
    localparam logic [CW-1:0] CAP_OFS = CW'(RAM_LAT - 1);

    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cyc, cyc_nx;
    logic [31:0]   lbuf, lbuf_nx;

    logic          op_valid;
    logic          op_store;
    logic [2:0]    nbytes;
    logic [CW-1:0] last_cyc;
    logic [1:0]    iss_idx;
    logic [1:0]    cap_idx;
    logic          cap_en;
    logic [31:0]   ld_data;

    // Decode the memory op into validity, direction and byte count.
    always_comb begin
        op_valid = 1'b1;
        op_store = ex_mem_op[3];
        nbytes   = 3'd1;
        case (ex_mem_op)
            4'b0001, 4'b0100, 4'b1001: nbytes = 3'd1;
            4'b0010, 4'b0101, 4'b1010: nbytes = 3'd2;
            4'b0011, 4'b1011:          nbytes = 3'd4;
            default: begin
                op_valid = 1'b0;
                op_store = 1'b0;
            end
        endcase
    end

    // Transfer bookkeeping: issue index saturates so ram_addr holds while
    // load bytes are still in flight; capture trails issue by RAM_LAT-1.
    always_comb begin
        last_cyc = op_store ? (CW'(nbytes) - CW'(1))
                            : (CW'(nbytes) + CAP_OFS - CW'(1));
        iss_idx  = (cyc < CW'(nbytes)) ? cyc[1:0] : 2'(nbytes - 3'd1);
        cap_idx  = 2'(cyc - CAP_OFS);
        cap_en   = (state == XFER) && !op_store
                   && (int'(cyc) >= int'(RAM_LAT) - 1);
    end

    // Sign/zero extension of the assembled load word.
    always_comb begin
        case (ex_mem_op)
            4'b0001: ld_data = {{24{lbuf[7]}}, lbuf[7:0]};
            4'b0010: ld_data = {{16{lbuf[15]}}, lbuf[15:0]};
            4'b0011: ld_data = lbuf;
            4'b0100: ld_data = {24'd0, lbuf[7:0]};
            4'b0101: ld_data = {16'd0, lbuf[15:0]};
            default: ld_data = 32'd0;
        endcase
    end

    // State, byte counter and load buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cyc   <= '0;
            lbuf  <= 32'd0;
        end else begin
            state <= state_nx;
            cyc   <= cyc_nx;
            lbuf  <= lbuf_nx;
        end
    end

    // Next-state logic; grant is only looked at in IDLE and REQ.
    always_comb begin
        state_nx = state;
        cyc_nx   = cyc;
        lbuf_nx  = lbuf;
        case (state)
            IDLE: begin
                cyc_nx  = '0;
                lbuf_nx = 32'd0;
                if (op_valid) state_nx = mem_gnt ? XFER : REQ;
            end
            REQ: begin
                if (mem_gnt) state_nx = XFER;
            end
            XFER: begin
                if (cap_en) lbuf_nx[{cap_idx, 3'b000} +: 8] = ram_din;
                if (cyc == last_cyc) begin
                    state_nx = DONE;
                    cyc_nx   = '0;
                end else begin
                    cyc_nx = cyc + CW'(1);
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode; everything is forced low while reset is asserted.
    always_comb begin
        mem_wdata = 32'd0;
        mem_wd    = 5'd0;
        mem_wreg  = 1'b0;
        stallreq  = 1'b0;
        mem_req   = 1'b0;
        ram_addr  = 32'd0;
        ram_dout  = 8'd0;
        ram_we    = 1'b0;
        case (state)
            IDLE: begin
                if (op_valid) begin
                    stallreq = 1'b1;
                    mem_req  = 1'b1;
                end else begin
                    mem_wdata = ex_wdata;
                    mem_wd    = ex_wd;
                    mem_wreg  = ex_wreg;
                end
            end
            REQ: begin
                stallreq = 1'b1;
                mem_req  = 1'b1;
            end
            XFER: begin
                stallreq = 1'b1;
                mem_req  = 1'b1;
                ram_addr = ex_mem_addr + 32'(iss_idx);
                if (op_store) begin
                    ram_dout = ex_sdata[{iss_idx, 3'b000} +: 8];
                    ram_we   = 1'b1;
                end
            end
            DONE: begin
                mem_wdata = ld_data;
                mem_wd    = ex_wd;
                mem_wreg  = ex_wreg;
            end
            default: ;
        endcase
        if (rst) begin
            mem_wdata = 32'd0;
            mem_wd    = 5'd0;
            mem_wreg  = 1'b0;
            stallreq  = 1'b0;
            mem_req   = 1'b0;
            ram_addr  = 32'd0;
            ram_dout  = 8'd0;
            ram_we    = 1'b0;
        end
    end

endmodule
